lock_controller: RTL and testbench

//  Code-entry and lock state machine for the electronic lock, upstream of the 4-digit strobed display driver.
//  - Debounces the four push buttons and takes a 4-digit hex code, one digit at a time, from the 4 slide switches.
//  - Compares the entered code with a stored combination and drives the unlock and alarm outputs.
//  - Supplies the four digit nibbles that the display driver multiplexes onto the seven-segment display.

---
 rtl/lock_controller_pkg.sv | 26 ++
 rtl/lock_controller_btn_debounce.sv | 38 +++
 rtl/lock_controller.sv | 191 +++++++++++++++++++
 tb/tb_lock_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_controller_pkg.sv
// Shared definitions for the electronic lock: FSM states, button indices,
// decoded button commands and the lockout display nibble.
package lock_controller_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_ENTER  = 3'd1,
        CMD_CLEAR  = 3'd2,
        CMD_SUBMIT = 3'd3,
        CMD_SET    = 3'd4
    } lock_cmd_t;

    localparam int BTN_ENTER  = 3;
    localparam int BTN_CLEAR  = 2;
    localparam int BTN_SUBMIT = 1;
    localparam int BTN_SET    = 0;

    localparam logic [3:0] LOCKOUT_NIBBLE = 4'hE;

endpackage

// File: rtl/lock_controller_btn_debounce.sv
// Single-button debouncer: the level follows raw only after raw has held a new
// value for DEBOUNCE_CYCLES consecutive clocks; a press yields a 1-cycle pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            cnt        <= '0;
        end else begin
            rise_pulse <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= raw;
                rise_pulse <= raw;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Code-entry and lock FSM: debounced buttons build a 4-digit entry that is
// checked against the stored combination, driving unlock/alarm and the display.
module lock_controller
    import lock_controller_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          UNLOCK_CYCLES   = 250000000,
    parameter int          LOCKOUT_CYCLES  = 500000000,
    parameter int          MAX_TRIES       = 3,
    parameter logic [15:0] RESET_CODE      = 16'h1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  switch,
    input  logic [3:0]  btn,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic [3:0]  led,
    output logic        unlocked,
    output logic        alarm
);

    localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : gen_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .raw       (btn[i]),
            .level     (btn_level[i]),
            .rise_pulse(btn_pulse[i])
        );
    end

    // A press is a rising pulse while the debounced level is held high.
    assign press = btn_pulse & btn_level;

    lock_state_t        state, state_d;
    lock_cmd_t          cmd;
    logic [15:0]        entry, entry_d;
    logic [15:0]        code, code_d;
    logic [2:0]         ptr, ptr_d;
    logic [2:0]         tries, tries_d, tries_inc;
    logic [TIMER_W-1:0] timer, timer_d;
    logic               full;

    always_comb begin
        cmd = CMD_NONE;
        if      (press[BTN_CLEAR])  cmd = CMD_CLEAR;
        else if (press[BTN_SUBMIT]) cmd = CMD_SUBMIT;
        else if (press[BTN_SET])    cmd = CMD_SET;
        else if (press[BTN_ENTER])  cmd = CMD_ENTER;
    end

    assign full      = (ptr == 3'd4);
    assign tries_inc = (tries == 3'd7) ? 3'd7 : tries + 3'd1;

    // NOTE: every next-state variable gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        entry_d = entry;
        code_d  = code;
        ptr_d   = ptr;
        tries_d = tries;
        timer_d = timer;

        case (state)
            ST_LOCKED: begin
                case (cmd)
                    CMD_CLEAR: begin
                        entry_d = '0;
                        ptr_d   = '0;
                    end
                    CMD_SUBMIT: begin
                        if (full) begin
                            entry_d = '0;
                            ptr_d   = '0;
                            if (entry == code) begin
                                state_d = ST_OPEN;
                                tries_d = '0;
                                timer_d = UNLOCK_LOAD;
                            end else begin
                                tries_d = tries_inc;
                                if (tries_inc >= 3'(MAX_TRIES)) begin
                                    state_d = ST_LOCKOUT;
                                    timer_d = LOCKOUT_LOAD;
                                end
                            end
                        end
                    end
                    CMD_ENTER: begin
                        if (!full) begin
                            entry_d[4*(3-int'(ptr[1:0])) +: 4] = switch;
                            ptr_d = ptr + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end

            ST_OPEN: begin
                if (timer == '0) begin
                    state_d = ST_LOCKED;
                    entry_d = '0;
                    ptr_d   = '0;
                end else begin
                    timer_d = timer - 1'b1;
                    case (cmd)
                        CMD_CLEAR: begin
                            state_d = ST_LOCKED;
                            entry_d = '0;
                            ptr_d   = '0;
                        end
                        CMD_SET: begin
                            if (full) begin
                                code_d  = entry;
                                entry_d = '0;
                                ptr_d   = '0;
                                timer_d = UNLOCK_LOAD;
                            end
                        end
                        CMD_ENTER: begin
                            if (!full) begin
                                entry_d[4*(3-int'(ptr[1:0])) +: 4] = switch;
                                ptr_d = ptr + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_d = ST_LOCKED;
                    tries_d = '0;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end

            default: state_d = ST_LOCKED;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOCKED;
            entry     <= '0;
            code      <= RESET_CODE;
            ptr       <= '0;
            tries     <= '0;
            timer     <= '0;
            digits    <= '0;
            dig_valid <= '0;
            led       <= '0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state    <= state_d;
            entry    <= entry_d;
            code     <= code_d;
            ptr      <= ptr_d;
            tries    <= tries_d;
            timer    <= timer_d;
            led      <= switch;
            unlocked <= (state_d == ST_OPEN);
            alarm    <= (state_d == ST_LOCKOUT);
            if (state_d == ST_LOCKOUT) begin
                digits    <= {4{LOCKOUT_NIBBLE}};
                dig_valid <= 4'hF;
            end else begin
                digits    <= entry_d;
                dig_valid <= ~(4'hF >> ptr_d);
            end
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller with short debounce and
// timer settings; a second instance with a long unlock window covers SET.
module tb_lock_controller;
    import lock_controller_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  switch = '0;
    logic [3:0]  btn = '0;
    logic [15:0] digits,  digits2;
    logic [3:0]  dig_valid, dig_valid2;
    logic [3:0]  led, led2;
    logic        unlocked, unlocked2;
    logic        alarm, alarm2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lock_controller #(
        .DEBOUNCE_CYCLES(DB),
        .UNLOCK_CYCLES  (20),
        .LOCKOUT_CYCLES (30)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .switch   (switch),
        .btn      (btn),
        .digits   (digits),
        .dig_valid(dig_valid),
        .led      (led),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    lock_controller #(
        .DEBOUNCE_CYCLES(DB),
        .UNLOCK_CYCLES  (200),
        .LOCKOUT_CYCLES (30)
    ) dut_set (
        .clk      (clk),
        .rst      (rst),
        .switch   (switch),
        .btn      (btn),
        .digits   (digits2),
        .dig_valid(dig_valid2),
        .led      (led2),
        .unlocked (unlocked2),
        .alarm    (alarm2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (DB + 1) tick();
        btn[idx] = 1'b0;
        repeat (DB + 1) tick();
    endtask

    task automatic enter_code(input logic [15:0] value);
        for (int i = 0; i < 4; i++) begin
            switch = value[15-4*i -: 4];
            press(BTN_ENTER);
        end
    endtask

    initial begin
        // 1: reset state, correct code, exact open latency and relock time
        do_reset();
        check("rst_digits", digits, 16'h0);
        check("rst_dig_valid", dig_valid, 4'h0);
        check("rst_led", led, 4'h0);
        check("rst_unlocked", unlocked, 1'b0);
        check("rst_alarm", alarm, 1'b0);
        enter_code(16'h1234);
        check("t1_entry", digits, 16'h1234);
        check("t1_dig_valid", dig_valid, 4'hF);
        check("t1_led", led, 4'h4);
        btn[BTN_SUBMIT] = 1'b1;
        repeat (DB) tick();
        check("t1_before_open", unlocked, 1'b0);
        tick();
        check("t1_open", unlocked, 1'b1);
        check("t1_open_digits", digits, 16'h0);
        btn[BTN_SUBMIT] = 1'b0;
        repeat (19) tick();
        check("t1_last_open", unlocked, 1'b1);
        tick();
        check("t1_relock", unlocked, 1'b0);
        check("t1_relock_digits", digits, 16'h0);

        // 2: short bouncing presses are rejected, a clean hold gives one digit
        switch = 4'h7;
        for (int i = 0; i < 10; i++) begin
            btn[BTN_ENTER] = 1'b1;
            repeat (3) tick();
            btn[BTN_ENTER] = 1'b0;
            tick();
        end
        check("t2_bounce_valid", dig_valid, 4'h0);
        check("t2_bounce_digits", digits, 16'h0);
        btn[BTN_ENTER] = 1'b1;
        repeat (5) tick();
        btn[BTN_ENTER] = 1'b0;
        repeat (5) tick();
        check("t2_one_pulse_valid", dig_valid, 4'h8);
        check("t2_one_pulse_digits", digits, 16'h7000);
        press(BTN_CLEAR);
        check("t2_clear", dig_valid, 4'h0);

        // 3: three wrong codes force lockout; buttons ignored; then recovery
        enter_code(16'h1235);
        press(BTN_SUBMIT);
        check("t3_tries1", dut.tries, 3'd1);
        check("t3_fail1_unlocked", unlocked, 1'b0);
        check("t3_fail1_digits", digits, 16'h0);
        enter_code(16'h1235);
        press(BTN_SUBMIT);
        check("t3_tries2", dut.tries, 3'd2);
        check("t3_fail2_alarm", alarm, 1'b0);
        enter_code(16'h1235);
        btn[BTN_SUBMIT] = 1'b1;
        repeat (DB + 1) tick();
        check("t3_alarm", alarm, 1'b1);
        check("t3_eeee", digits, 16'hEEEE);
        check("t3_valid_f", dig_valid, 4'hF);
        btn[BTN_SUBMIT] = 1'b0;
        repeat (DB + 1) tick();
        switch = 4'h9;
        press(BTN_ENTER);
        check("t3_ignored_digits", digits, 16'hEEEE);
        check("t3_ignored_alarm", alarm, 1'b1);
        repeat (14) tick();
        check("t3_last_alarm", alarm, 1'b1);
        tick();
        check("t3_alarm_off", alarm, 1'b0);
        check("t3_after_digits", digits, 16'h0);
        check("t3_after_valid", dig_valid, 4'h0);
        check("t3_tries_zero", dut.tries, 3'd0);

        // 4: SET a new combination while open (long-window instance)
        do_reset();
        enter_code(16'h1234);
        press(BTN_SUBMIT);
        check("t4_open", unlocked2, 1'b1);
        enter_code(16'h9ABC);
        check("t4_entry", digits2, 16'h9ABC);
        press(BTN_SET);
        check("t4_code", dut_set.code, 16'h9ABC);
        check("t4_set_digits", digits2, 16'h0);
        check("t4_still_open", unlocked2, 1'b1);
        press(BTN_CLEAR);
        check("t4_clear_relock", unlocked2, 1'b0);
        enter_code(16'h1234);
        press(BTN_SUBMIT);
        check("t4_old_fails", unlocked2, 1'b0);
        check("t4_old_tries", dut_set.tries, 3'd1);
        enter_code(16'h9ABC);
        press(BTN_SUBMIT);
        check("t4_new_opens", unlocked2, 1'b1);

        // 5: no wrap past 4 digits, short SUBMIT, CLEAR beats ENTER
        do_reset();
        enter_code(16'h1234);
        switch = 4'h5;
        press(BTN_ENTER);
        check("t5_no_wrap", digits, 16'h1234);
        check("t5_valid_f", dig_valid, 4'hF);
        press(BTN_CLEAR);
        switch = 4'h1;
        press(BTN_ENTER);
        switch = 4'h2;
        press(BTN_ENTER);
        press(BTN_SUBMIT);
        check("t5_short_tries", dut.tries, 3'd0);
        check("t5_short_digits", digits, 16'h1200);
        check("t5_short_valid", dig_valid, 4'hC);
        switch = 4'hF;
        btn[BTN_CLEAR] = 1'b1;
        btn[BTN_ENTER] = 1'b1;
        repeat (DB + 1) tick();
        btn = '0;
        repeat (DB + 1) tick();
        check("t5_prio_digits", digits, 16'h0);
        check("t5_prio_valid", dig_valid, 4'h0);

        // 6: reset while open and mid-entry; combination returns to default
        enter_code(16'h1234);
        press(BTN_SUBMIT);
        check("t6_open", unlocked, 1'b1);
        do_reset();
        check("t6_rst_unlocked", unlocked, 1'b0);
        check("t6_rst_digits", digits, 16'h0);
        check("t6_code_default", dut_set.code, 16'h1234);
        switch = 4'h3;
        press(BTN_ENTER);
        press(BTN_ENTER);
        check("t6_mid_entry", digits, 16'h3300);
        do_reset();
        check("t6_mid_rst_digits", digits, 16'h0);
        check("t6_mid_rst_valid", dig_valid, 4'h0);
        check("t6_led", led, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
